commit_trace_fifo: RTL and testbench

//  Captures one record per retired instruction from the core debug outputs and buffers it in a FIFO:
//  pc, instr, register writeback and data-memory write. A valid/ready port drains the records to the
//  DPI trace/difftest consumer, which may stall. Detects ebreak, stops capture, flags completion once drained.

---
 rtl/commit_trace_fifo.sv | 180 ++++++++++++++++++
 tb/tb_commit_trace_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_fifo
//  Description : Captures one record per retired instruction (pc, instr,
//                regfile writeback, data-memory store) into a first-word
//                fall-through FIFO that a stallable trace consumer drains.
//                Capture stops after an ebreak is stored; done flags the
//                drained end of the trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_fifo #(
    parameter int DEPTH   = 16,
    parameter bit MASK_X0 = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [31:0]               dbg_pc,
    input  logic [31:0]               dbg_instr,
    input  logic                      dbg_reg_we,
    input  logic [3:0]                dbg_rd,
    input  logic [31:0]               dbg_wdata,
    input  logic                      dbg_mem_we,
    input  logic [31:0]               dbg_mem_addr,
    input  logic [31:0]               dbg_mem_wdata,
    input  logic [3:0]                dbg_mem_wmask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_reg_we,
    output logic [3:0]                out_rd,
    output logic [31:0]               out_wdata,
    output logic                      out_mem_we,
    output logic [31:0]               out_mem_addr,
    output logic [31:0]               out_mem_wdata,
    output logic [3:0]                out_mem_wmask,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [15:0]               drop_cnt,
    output logic                      halted,
    output logic                      done
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam int              RW       = 170;
    localparam logic [CW-1:0]   C_FULL   = CW'(DEPTH);
    localparam logic [31:0]     C_EBREAK = 32'h0010_0073;
    localparam logic [15:0]     C_SAT    = 16'hFFFF;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            overflow_q;
    logic [15:0]     drop_cnt_q;
    logic [15:0]     drop_cnt_d;

    logic            w_pop;
    logic            w_capture;
    logic            w_push;
    logic            w_drop;
    logic [RW-1:0]   w_rec;
    logic [RW-1:0]   w_head;
    logic            w_head_reg_we;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign w_pop     = out_valid & out_ready;
    assign w_capture = in_valid & (state_q == S_RUN);
    assign w_push    = w_capture & ((count_q != C_FULL) | w_pop);
    assign w_drop    = w_capture & (count_q == C_FULL) & ~w_pop;

    assign w_rec = {dbg_pc, dbg_instr, dbg_reg_we, dbg_rd, dbg_wdata,
                    dbg_mem_we, dbg_mem_addr, dbg_mem_wdata, dbg_mem_wmask};

    // Head fields fall straight through from storage.
    assign w_head        = mem_q[rd_ptr_q];
    assign out_pc        = w_head[169:138];
    assign out_instr     = w_head[137:106];
    assign w_head_reg_we = w_head[105];
    assign out_rd        = w_head[104:101];
    assign out_wdata     = w_head[100:69];
    assign out_mem_we    = w_head[68];
    assign out_mem_addr  = w_head[67:36];
    assign out_mem_wdata = w_head[35:4];
    assign out_mem_wmask = w_head[3:0];

    // x0 writes are architecturally invisible; optionally hide them here.
    generate
        if (MASK_X0) begin : g_mask_x0
            assign out_reg_we = w_head_reg_we & (out_rd != 4'd0);
        end else begin : g_keep_x0
            assign out_reg_we = w_head_reg_we;
        end
    endgenerate

    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign halted    = (state_q != S_RUN);
    assign done      = (state_q == S_DONE);

    // Next occupancy and saturating drop counter.
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
        drop_cnt_d = drop_cnt_q;
        if (w_drop && (drop_cnt_q != C_SAT)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Record storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_rec;
        end
    end

    // Pointers, occupancy and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Capture FSM: halt after a stored ebreak, finish once the FIFO has drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (w_push && (dbg_instr == C_EBREAK)) begin
                        state_q <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (count_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_DONE;
                default: state_q <= S_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commit_trace_fifo
//  Description : Self-checking bench for commit_trace_fifo: a vector table,
//                directed corner sequences and randomized traffic compared
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_fifo;

    localparam int          DEPTH    = 16;
    localparam logic [31:0] C_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        reg_we;
        logic [3:0]  rd;
        logic [31:0] wdata;
        logic        mem_we;
        logic [31:0] addr;
        logic [31:0] mwdata;
        logic [3:0]  wmask;
    } rec_t;

    typedef struct {
        logic        in_valid;
        logic [31:0] pc;
        logic        rdy;
        logic        exp_valid;
        logic [4:0]  exp_count;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    rec_t        cur = '0;

    logic        o_valid, o_reg_we, o_mem_we, o_ovf, o_halt, o_done;
    logic [31:0] o_pc, o_instr, o_wdata, o_addr, o_mwdata;
    logic [3:0]  o_rd, o_wmask;
    logic [4:0]  o_count;
    logic [15:0] o_drop;

    logic        u_valid, u_reg_we, u_mem_we, u_ovf, u_halt, u_done;
    logic [31:0] u_pc, u_instr, u_wdata, u_addr, u_mwdata;
    logic [3:0]  u_rd, u_wmask;
    logic [4:0]  u_count;
    logic [15:0] u_drop;

    commit_trace_fifo #(.DEPTH(DEPTH), .MASK_X0(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .dbg_pc(cur.pc), .dbg_instr(cur.instr), .dbg_reg_we(cur.reg_we),
        .dbg_rd(cur.rd), .dbg_wdata(cur.wdata), .dbg_mem_we(cur.mem_we),
        .dbg_mem_addr(cur.addr), .dbg_mem_wdata(cur.mwdata), .dbg_mem_wmask(cur.wmask),
        .out_valid(o_valid), .out_ready(out_ready),
        .out_pc(o_pc), .out_instr(o_instr), .out_reg_we(o_reg_we), .out_rd(o_rd),
        .out_wdata(o_wdata), .out_mem_we(o_mem_we), .out_mem_addr(o_addr),
        .out_mem_wdata(o_mwdata), .out_mem_wmask(o_wmask),
        .count(o_count), .overflow(o_ovf), .drop_cnt(o_drop),
        .halted(o_halt), .done(o_done)
    );

    commit_trace_fifo #(.DEPTH(DEPTH), .MASK_X0(1'b0)) dut_nomask (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .dbg_pc(cur.pc), .dbg_instr(cur.instr), .dbg_reg_we(cur.reg_we),
        .dbg_rd(cur.rd), .dbg_wdata(cur.wdata), .dbg_mem_we(cur.mem_we),
        .dbg_mem_addr(cur.addr), .dbg_mem_wdata(cur.mwdata), .dbg_mem_wmask(cur.wmask),
        .out_valid(u_valid), .out_ready(out_ready),
        .out_pc(u_pc), .out_instr(u_instr), .out_reg_we(u_reg_we), .out_rd(u_rd),
        .out_wdata(u_wdata), .out_mem_we(u_mem_we), .out_mem_addr(u_addr),
        .out_mem_wdata(u_mwdata), .out_mem_wmask(u_wmask),
        .count(u_count), .overflow(u_ovf), .drop_cnt(u_drop),
        .halted(u_halt), .done(u_done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: record queue, sticky flags and a 3-phase capture status.
    rec_t q[$];
    bit   m_ovf;
    int   m_drop;
    int   m_phase;   // 0 capturing, 1 halted, 2 done

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_drop  = 0;
        m_phase = 0;
    endtask

    task automatic compare_model();
        chk("valid",    o_valid, q.size() > 0);
        chk("count",    o_count, q.size());
        chk("overflow", o_ovf,   m_ovf);
        chk("drop_cnt", o_drop,  m_drop);
        chk("halted",   o_halt,  m_phase != 0);
        chk("done",     o_done,  m_phase == 2);
        chk("nm_count", u_count, q.size());
        if (q.size() > 0) begin
            chk("pc",        o_pc,     q[0].pc);
            chk("instr",     o_instr,  q[0].instr);
            chk("reg_we",    o_reg_we, q[0].reg_we && (q[0].rd != 0));
            chk("nm_reg_we", u_reg_we, q[0].reg_we);
            chk("rd",        o_rd,     q[0].rd);
            chk("wdata",     o_wdata,  q[0].wdata);
            chk("mem_we",    o_mem_we, q[0].mem_we);
            chk("mem_addr",  o_addr,   q[0].addr);
            chk("mem_wdata", o_mwdata, q[0].mwdata);
            chk("mem_wmask", o_wmask,  q[0].wmask);
        end
    endtask

    // Check current outputs, then advance one clock and the model with it.
    task automatic tick();
        int  sz;
        bit  pop, room, push, drop;
        compare_model();
        sz   = q.size();
        pop  = (sz > 0) && out_ready;
        room = (sz < DEPTH) || pop;
        push = in_valid && (m_phase == 0) && room;
        drop = in_valid && (m_phase == 0) && !room;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(cur);
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            if (m_phase == 1 && sz == 0) m_phase = 2;
            else if (m_phase == 0 && push && cur.instr == C_EBREAK) m_phase = 1;
        end
        #1;
    endtask

    function automatic rec_t mk(input logic [31:0] pc);
        rec_t r;
        r        = '0;
        r.pc     = pc;
        r.instr  = 32'h0000_0013 | {pc[11:0], 20'h0};
        r.reg_we = 1'b1;
        r.rd     = pc[5:2];
        r.wdata  = ~pc;
        return r;
    endfunction

    vec_t vt[8];

    initial begin
        int readyp;
        vt[0] = '{1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0};
        vt[1] = '{1'b1, 32'h4, 1'b0, 1'b1, 5'd1, 32'h0};
        vt[2] = '{1'b1, 32'h8, 1'b0, 1'b1, 5'd2, 32'h0};
        vt[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 5'd3, 32'h0};
        vt[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 5'd3, 32'h0};
        vt[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 5'd2, 32'h4};
        vt[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 32'h8};
        vt[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0};

        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        tick();                       // reset-state outputs checked here
        rst = 1'b0;

        // Basic push then drain, from the vector table.
        for (int i = 0; i < 8; i++) begin
            in_valid  = vt[i].in_valid;
            cur       = mk(vt[i].pc);
            out_ready = vt[i].rdy;
            chk("t1_valid", o_valid, vt[i].exp_valid);
            chk("t1_count", o_count, vt[i].exp_count);
            if (vt[i].exp_valid) chk("t1_pc", o_pc, vt[i].exp_pc);
            tick();
        end

        // Overfill: 20 pushes into 16 slots with the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cur = mk(32'h100 + 32'(i) * 4);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_count", o_count, 5'd16);
        chk("t2_ovf",   o_ovf,   1'b1);
        chk("t2_drop",  o_drop,  16'd4);
        chk("t2_head",  o_pc,    32'h100);

        // Full FIFO streaming: pop frees the slot for the same-cycle push.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur = mk(32'h400 + 32'(i) * 4);
            tick();
        end
        chk("t3_count", o_count, 5'd16);
        chk("t3_drop",  o_drop,  16'd4);
        chk("t3_head",  o_pc,    32'h128);
        in_valid = 1'b0;
        repeat (17) tick();

        // x0 writeback masking.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        cur        = '0;
        cur.pc     = 32'h500;
        cur.instr  = 32'h0010_0013;
        cur.reg_we = 1'b1;
        cur.rd     = 4'd0;
        cur.wdata  = 32'h1;
        tick();
        in_valid = 1'b0;
        chk("t4_we_mask",   o_reg_we, 1'b0);
        chk("t4_we_nomask", u_reg_we, 1'b1);
        out_ready = 1'b1;
        tick();

        // Store record reproduced exactly.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        cur         = '0;
        cur.pc      = 32'h504;
        cur.instr   = 32'h00f1_2123;
        cur.mem_we  = 1'b1;
        cur.addr    = 32'h8000_0102;
        cur.wmask   = 4'b1100;
        cur.mwdata  = 32'hABCD_0000;
        tick();
        in_valid = 1'b0;
        chk("t5_mem_we", o_mem_we, 1'b1);
        chk("t5_addr",   o_addr,   32'h8000_0102);
        chk("t5_wmask",  o_wmask,  4'b1100);
        chk("t5_wdata",  o_mwdata, 32'hABCD_0000);
        out_ready = 1'b1;
        tick();

        // ebreak halts capture; done one cycle after the final pop.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur = mk(32'h600); tick();
        cur = mk(32'h604); tick();
        cur = mk(32'h608); cur.instr = C_EBREAK; tick();
        for (int i = 0; i < 4; i++) begin
            cur = mk(32'h60C + 32'(i) * 4);
            tick();
        end
        chk("t6_halted", o_halt,  1'b1);
        chk("t6_count",  o_count, 5'd3);
        chk("t6_done0",  o_done,  1'b0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t6_empty",  o_count, 5'd0);
        chk("t6_done1",  o_done,  1'b0);
        tick();
        chk("t6_done2",  o_done,  1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_halt", o_halt,  1'b0);
        chk("t6_rst_done", o_done,  1'b0);
        chk("t6_rst_ovf",  o_ovf,   1'b0);
        chk("t6_rst_cnt",  o_count, 5'd0);

        // Drop counter saturation.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 65560; i++) begin
            cur = mk(32'(i) * 4);
            tick();
        end
        chk("sat_drop", o_drop, 16'hFFFF);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized traffic with occasional ebreaks and mid-run resets.
        readyp = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) readyp = (i / 200) % 3 == 0 ? 15 : ((i / 200) % 3 == 1 ? 55 : 95);
            rst        = ($urandom % 400) == 0;
            in_valid   = ($urandom % 4) != 0;
            out_ready  = ($urandom % 100) < readyp;
            cur.pc     = $urandom;
            cur.instr  = (($urandom % 150) == 0) ? C_EBREAK : $urandom;
            cur.reg_we = $urandom;
            cur.rd     = $urandom;
            cur.wdata  = $urandom;
            cur.mem_we = $urandom;
            cur.addr   = $urandom;
            cur.mwdata = $urandom;
            cur.wmask  = $urandom;
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
